// File: rtl/game_state_sequencer.sv
// Game flow controller: latches per-pixel collision flags each frame, sequences IDLE/PLAY/HIT/LEVEL_UP/GAME_OVER,
// and keeps score, lives and level. Updates land on the clock edge ending the startOfFrame cycle; start_key acts any cycle.
// No backpressure: pulse outputs last exactly one clk. Optional bonus-life logic is built only when BONUS_LIFE_EN is defined.
//
// Ports:
//   clk, resetN (async active-low), startOfFrame (1-cycle frame pulse), start_key (level, rising edge used)
//   tile/prize/gate/step_free_collision (per-pixel contact flags)
//   game_state[2:0], score[13:0], lives[2:0], level[3:0], freeze_motion, respawnPulse, soundPulse
module game_state_sequencer #(
  parameter int INIT_LIVES   = 3,
  parameter int MAX_LIVES    = 7,
  parameter int PRIZE_POINTS = 10,
  parameter int SCORE_MAX    = 9999,
  parameter int HIT_FRAMES   = 60,
  parameter int LEVEL_FRAMES = 90,
  parameter int MAX_LEVEL    = 9
`ifdef BONUS_LIFE_EN
  ,
  parameter int BONUS_SCORE  = 500
`endif
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        start_key,
  input  logic        tile_collision,
  input  logic        prize_collision,
  input  logic        gate_collision,
  input  logic        step_free_collision,
  output logic [2:0]  game_state,
  output logic [13:0] score,
  output logic [2:0]  lives,
  output logic [3:0]  level,
  output logic        freeze_motion,
  output logic        respawnPulse,
  output logic        soundPulse
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_HIT       = 3'd2,
    ST_LEVEL_UP  = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  localparam int TMAX = (HIT_FRAMES > LEVEL_FRAMES) ? HIT_FRAMES : LEVEL_FRAMES;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] HIT_T     = TW'(HIT_FRAMES);
  localparam logic [TW-1:0] LEVEL_T   = TW'(LEVEL_FRAMES);
  localparam logic [14:0]   PRIZE15   = 15'(PRIZE_POINTS);
  localparam logic [14:0]   SMAX15    = 15'(SCORE_MAX);
  localparam logic [2:0]    INIT_L    = 3'(INIT_LIVES);
  localparam logic [2:0]    MAX_L     = 3'(MAX_LIVES);
  localparam logic [3:0]    MAX_LVL   = 4'(MAX_LEVEL);

  state_t          state_q, state_d;
  logic [13:0]     score_q, score_d;
  logic [2:0]      lives_q, lives_d;
  logic [3:0]      level_q, level_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            tile_lat, prize_lat, gate_lat, step_lat;
  logic            tile_d, prize_d, gate_d, step_d;
  logic            start_prev;
  logic            resp_q, resp_d;
  logic            sound_q, sound_d;

  logic            start_rise;
  logic [14:0]     score_sum;
  logic [13:0]     score_clamp;
  logic [2:0]      lives_base;
  logic            bonus_hit;

  assign start_rise = start_key & ~start_prev;

  // Prize and step-free stack in one frame; sum is 15 bits so it cannot wrap before the clamp.
  assign score_sum   = {1'b0, score_q} + (prize_lat ? PRIZE15 : 15'd0) + {14'd0, step_lat};
  assign score_clamp = (score_sum > SMAX15) ? SMAX15[13:0] : score_sum[13:0];

`ifdef BONUS_LIFE_EN
  localparam logic [14:0] BONUS15 = 15'(BONUS_SCORE);
  // A bonus is due when the post-clamp score enters a higher BONUS_SCORE band.
  assign bonus_hit = (({1'b0, score_clamp} / BONUS15) > ({1'b0, score_q} / BONUS15));
`else
  assign bonus_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      score_q    <= 14'd0;
      lives_q    <= INIT_L;
      level_q    <= 4'd1;
      timer_q    <= '0;
      tile_lat   <= 1'b0;
      prize_lat  <= 1'b0;
      gate_lat   <= 1'b0;
      step_lat   <= 1'b0;
      start_prev <= 1'b0;
      resp_q     <= 1'b0;
      sound_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      level_q    <= level_d;
      timer_q    <= timer_d;
      tile_lat   <= tile_d;
      prize_lat  <= prize_d;
      gate_lat   <= gate_d;
      step_lat   <= step_d;
      start_prev <= start_key;
      resp_q     <= resp_d;
      sound_q    <= sound_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    lives_d    = lives_q;
    level_d    = level_q;
    timer_d    = timer_q;
    resp_d     = 1'b0;
    sound_d    = 1'b0;
    lives_base = lives_q;

    // On a frame boundary the old frame's flags are consumed and the latch restarts
    // with this cycle's inputs, so a coincident collision counts toward the new frame.
    if (startOfFrame) begin
      tile_d  = tile_collision;
      prize_d = prize_collision;
      gate_d  = gate_collision;
      step_d  = step_free_collision;
    end else begin
      tile_d  = tile_lat  | tile_collision;
      prize_d = prize_lat | prize_collision;
      gate_d  = gate_lat  | gate_collision;
      step_d  = step_lat  | step_free_collision;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d = ST_PLAY;
          score_d = 14'd0;
          lives_d = INIT_L;
          level_d = 4'd1;
          resp_d  = 1'b1;
          tile_d  = 1'b0;
          prize_d = 1'b0;
          gate_d  = 1'b0;
          step_d  = 1'b0;
        end
      end

      ST_PLAY: begin
        if (startOfFrame) begin
          if (tile_lat) begin
            if (lives_q != 3'd1) begin
              lives_base = lives_q - 3'd1;
              state_d    = ST_HIT;
              timer_d    = HIT_T;
            end else begin
              state_d    = ST_GAME_OVER;
            end
          end else if (gate_lat) begin
            state_d = ST_LEVEL_UP;
            level_d = (level_q >= MAX_LVL) ? MAX_LVL : level_q + 4'd1;
            timer_d = LEVEL_T;
          end
          score_d = score_clamp;
          sound_d = tile_lat | gate_lat | prize_lat;
          // Bonus is applied after the tile decrement, so a hit and a bonus cancel out.
          if (bonus_hit) begin
            sound_d = 1'b1;
            if (lives_base < MAX_L) begin
              lives_base = lives_base + 3'd1;
            end
          end
          // The last life lost always ends the game, bonus or not.
          lives_d = (tile_lat && (lives_q == 3'd1)) ? 3'd0 : lives_base;
        end
      end

      ST_HIT, ST_LEVEL_UP: begin
        // Collisions are still latched here but never scored.
        if (startOfFrame) begin
          if (timer_q <= TW'(1)) begin
            state_d = ST_PLAY;
            timer_d = '0;
            resp_d  = 1'b1;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end

      ST_GAME_OVER: begin
        if (start_rise) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign game_state    = state_q;
  assign score         = score_q;
  assign lives         = lives_q;
  assign level         = level_q;
  assign freeze_motion = (state_q != ST_PLAY);
  assign respawnPulse  = resp_q;
  assign soundPulse    = sound_q;

endmodule

// File: tb/tb_game_state_sequencer.sv
// Directed bench for game_state_sequencer: a table of per-frame vectors with expected outputs,
// followed by hand-written sequences for saturation, frame-boundary latching and async reset.
// Frames are short (a few clk) so long HIT/LEVEL_UP timers stay cheap.
module tb_game_state_sequencer;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        start_key;
  logic        tile_collision;
  logic        prize_collision;
  logic        gate_collision;
  logic        step_free_collision;
  logic [2:0]  game_state;
  logic [13:0] score;
  logic [2:0]  lives;
  logic [3:0]  level;
  logic        freeze_motion;
  logic        respawnPulse;
  logic        soundPulse;

  int tests_run = 0;
  int tests_failed = 0;

  game_state_sequencer dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .start_key           (start_key),
    .tile_collision      (tile_collision),
    .prize_collision     (prize_collision),
    .gate_collision      (gate_collision),
    .step_free_collision (step_free_collision),
    .game_state          (game_state),
    .score               (score),
    .lives               (lives),
    .level               (level),
    .freeze_motion       (freeze_motion),
    .respawnPulse        (respawnPulse),
    .soundPulse          (soundPulse)
  );

  always #5 clk = ~clk;

  localparam int OP_FRAME = 0;
  localparam int OP_KEY   = 1;

  typedef struct {
    int op;
    int t, p, g, s;
    int hold;
    int reps;
    int st, sc, lv, lvl, snd, rsp;
  } vec_t;

  vec_t vecs[19];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int st, input int sc, input int lv,
                            input int lvl, input int snd, input int rsp);
    chk({tag, " state"},  int'(game_state), st);
    chk({tag, " score"},  int'(score), sc);
    chk({tag, " lives"},  int'(lives), lv);
    chk({tag, " level"},  int'(level), lvl);
    chk({tag, " freeze"}, int'(freeze_motion), (st != 1) ? 1 : 0);
    chk({tag, " sound"},  int'(soundPulse), snd);
    chk({tag, " respawn"}, int'(respawnPulse), rsp);
  endtask

  // Collisions held for 'hold' cycles, then a clean startOfFrame cycle; returns just after that edge.
  task automatic do_frame(input int t, input int p, input int g, input int s, input int hold);
    tile_collision      = t[0];
    prize_collision     = p[0];
    gate_collision      = g[0];
    step_free_collision = s[0];
    for (int i = 0; i < hold; i++) tick();
    tile_collision      = 1'b0;
    prize_collision     = 1'b0;
    gate_collision      = 1'b0;
    step_free_collision = 1'b0;
    startOfFrame = 1'b1;
    tick();
    startOfFrame = 1'b0;
  endtask

  task automatic press_key_and_check(input string tag, input int st, input int sc, input int lv,
                                     input int lvl, input int snd, input int rsp);
    start_key = 1'b1;
    tick();
    check_outs(tag, st, sc, lv, lvl, snd, rsp);
    start_key = 1'b0;
    tick();
  endtask

  function automatic vec_t mk(int op, int t, int p, int g, int s, int hold, int reps,
                              int st, int sc, int lv, int lvl, int snd, int rsp);
    vec_t v;
    v.op = op; v.t = t; v.p = p; v.g = g; v.s = s; v.hold = hold; v.reps = reps;
    v.st = st; v.sc = sc; v.lv = lv; v.lvl = lvl; v.snd = snd; v.rsp = rsp;
    return v;
  endfunction

  initial begin
    //                op        t  p  g  s  hold reps  st  sc  lv lvl snd rsp
    vecs[0]  = mk(OP_KEY,   0, 0, 0, 0, 0,  1,   1,  0, 3, 1, 0, 1);
    vecs[1]  = mk(OP_FRAME, 0, 1, 0, 1, 50, 1,   1, 11, 3, 1, 1, 0);
    vecs[2]  = mk(OP_FRAME, 0, 0, 0, 0, 1,  1,   1, 11, 3, 1, 0, 0);
    vecs[3]  = mk(OP_FRAME, 1, 0, 1, 0, 1,  1,   2, 11, 2, 1, 1, 0);
    vecs[4]  = mk(OP_FRAME, 1, 1, 1, 1, 1,  59,  2, 11, 2, 1, 0, 0);
    vecs[5]  = mk(OP_FRAME, 1, 1, 1, 0, 1,  1,   1, 11, 2, 1, 0, 1);
    vecs[6]  = mk(OP_KEY,   0, 0, 0, 0, 0,  1,   1, 11, 2, 1, 0, 0);
    vecs[7]  = mk(OP_FRAME, 0, 0, 1, 0, 1,  1,   3, 11, 2, 2, 1, 0);
    vecs[8]  = mk(OP_FRAME, 0, 0, 0, 0, 1,  89,  3, 11, 2, 2, 0, 0);
    vecs[9]  = mk(OP_FRAME, 0, 0, 0, 0, 1,  1,   1, 11, 2, 2, 0, 1);
    vecs[10] = mk(OP_FRAME, 1, 0, 0, 0, 1,  1,   2, 11, 1, 2, 1, 0);
    vecs[11] = mk(OP_FRAME, 0, 0, 0, 0, 1,  60,  1, 11, 1, 2, 0, 1);
    vecs[12] = mk(OP_FRAME, 0, 1, 0, 0, 1,  1,   1, 21, 1, 2, 1, 0);
    vecs[13] = mk(OP_FRAME, 0, 0, 0, 1, 1,  1,   1, 22, 1, 2, 0, 0);
    vecs[14] = mk(OP_FRAME, 1, 0, 0, 0, 1,  1,   4, 22, 0, 2, 1, 0);
    vecs[15] = mk(OP_FRAME, 1, 1, 0, 0, 1,  1,   4, 22, 0, 2, 0, 0);
    vecs[16] = mk(OP_KEY,   0, 0, 0, 0, 0,  1,   0, 22, 0, 2, 0, 0);
    vecs[17] = mk(OP_FRAME, 0, 1, 0, 0, 1,  1,   0, 22, 0, 2, 0, 0);
    vecs[18] = mk(OP_KEY,   0, 0, 0, 0, 0,  1,   1,  0, 3, 1, 0, 1);

    resetN = 1'b0;
    startOfFrame = 1'b0;
    start_key = 1'b0;
    tile_collision = 1'b0;
    prize_collision = 1'b0;
    gate_collision = 1'b0;
    step_free_collision = 1'b0;
    repeat (3) tick();
    resetN = 1'b1;
    tick();
    check_outs("reset", 0, 0, 3, 1, 0, 0);

    // Idle frames do nothing.
    do_frame(1, 1, 1, 1, 2);
    check_outs("idle_frame", 0, 0, 3, 1, 0, 0);

    for (int i = 0; i < 19; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].op == OP_KEY) begin
        press_key_and_check(tag, vecs[i].st, vecs[i].sc, vecs[i].lv, vecs[i].lvl,
                            vecs[i].snd, vecs[i].rsp);
      end else begin
        for (int r = 0; r < vecs[i].reps; r++)
          do_frame(vecs[i].t, vecs[i].p, vecs[i].g, vecs[i].s, vecs[i].hold);
        check_outs(tag, vecs[i].st, vecs[i].sc, vecs[i].lv, vecs[i].lvl,
                   vecs[i].snd, vecs[i].rsp);
      end
    end

    // Respawn pulse from the last new-game press is gone one cycle later.
    chk("respawn_one_cycle", int'(respawnPulse), 0);

    // A collision on the startOfFrame cycle belongs to the next frame.
    prize_collision = 1'b1;
    startOfFrame = 1'b1;
    tick();
    prize_collision = 1'b0;
    startOfFrame = 1'b0;
    chk("sof_coincident score", int'(score), 0);
    chk("sof_coincident sound", int'(soundPulse), 0);
    do_frame(0, 0, 0, 0, 1);
    chk("sof_next score", int'(score), 10);
    chk("sof_next sound", int'(soundPulse), 1);
    tick();
    chk("sound_one_cycle", int'(soundPulse), 0);

    // Score saturation.
    for (int i = 0; i < 998; i++) do_frame(0, 1, 0, 0, 1);
    chk("score_9990", int'(score), 9990);
    do_frame(0, 1, 0, 1, 1);
    chk("score_clamp", int'(score), 9999);
    do_frame(0, 1, 0, 0, 1);
    chk("score_hold_max", int'(score), 9999);
    chk("score_max state", int'(game_state), 1);

    // Level saturation: climb to MAX_LEVEL, then one more gate.
    for (int i = 0; i < 8; i++) begin
      do_frame(0, 0, 1, 0, 1);
      for (int r = 0; r < 90; r++) do_frame(0, 0, 0, 0, 1);
    end
    chk("level_9", int'(level), 9);
    chk("level_9 state", int'(game_state), 1);
    do_frame(0, 0, 1, 0, 1);
    chk("level_sat level", int'(level), 9);
    chk("level_sat state", int'(game_state), 3);
    chk("level_sat sound", int'(soundPulse), 1);
    for (int r = 0; r < 89; r++) do_frame(0, 0, 0, 0, 1);
    chk("level_wait state", int'(game_state), 3);
    do_frame(0, 0, 0, 0, 1);
    chk("level_exit state", int'(game_state), 1);
    chk("level_exit respawn", int'(respawnPulse), 1);

    // Asynchronous reset in the middle of a HIT.
    do_frame(1, 0, 0, 0, 1);
    chk("pre_reset state", int'(game_state), 2);
    #3;
    resetN = 1'b0;
    #1;
    check_outs("async_reset", 0, 0, 3, 1, 0, 0);
    #2;
    resetN = 1'b1;
    tick();
    check_outs("after_reset", 0, 0, 3, 1, 0, 0);

`ifdef BONUS_LIFE_EN
    press_key_and_check("bonus_start", 1, 0, 3, 1, 0, 1);
    for (int i = 0; i < 49; i++) do_frame(0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) do_frame(0, 0, 0, 1, 1);
    check_outs("bonus_495", 1, 495, 3, 1, 0, 0);
    do_frame(0, 1, 0, 0, 1);
    check_outs("bonus_505", 1, 505, 4, 1, 1, 0);
    for (int i = 0; i < 200; i++) do_frame(0, 1, 0, 0, 1);
    check_outs("bonus_sat", 1, 2505, 7, 1, 1, 0);
    for (int i = 0; i < 49; i++) do_frame(0, 1, 0, 0, 1);
    chk("bonus_2995", int'(score), 2995);
    do_frame(1, 1, 0, 0, 1);
    check_outs("bonus_tile_net", 2, 3005, 7, 1, 1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
